wallace_mult_pipe: RTL and testbench

- Parametrised, pipelined Wallace-tree multiplier. Successor to the team's 16x16 combinational multiplier.
- Adds configurable operand width, a per-transaction signed/unsigned mode, registered pipeline stages, and a valid/ready handshake with backpressure.
- Sits between operand producers (datapath/DSP front end) and any consumer that may stall.

---
 rtl/wallace_pkg.sv | 52 +++++
 rtl/wallace_csa_row.sv | 21 ++
 rtl/wallace_mult_pipe.sv | 148 ++++++++++++++
 tb/tb_wallace_mult_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wallace_pkg.sv
// Shared constants, stage-control type and elaboration-time helpers for the
// pipelined Wallace-tree multiplier.
package wallace_pkg;

    localparam int NUM_STAGES = 3;
    localparam int MAX_TAG_W  = 16;

    typedef struct packed {
        logic                 valid;
        logic                 signed_mode;
        logic [MAX_TAG_W-1:0] tag;
    } stage_ctrl_t;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    // Baugh-Wooley adds a one at column w and at column 2w-1.
    function automatic logic [127:0] bw_correction(input int w);
        logic [127:0] c;
        c          = '0;
        c[w]       = 1'b1;
        c[2*w-1]   = 1'b1;
        return c;
    endfunction

    function automatic int rows_after(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    function automatic int num_layers(input int n);
        int rows;
        int count;
        rows  = n;
        count = 0;
        while (rows > 2) begin
            rows  = rows_after(rows);
            count = count + 1;
        end
        return count;
    endfunction

    function automatic int rows_at_layer(input int n0, input int layer);
        int rows;
        rows = n0;
        for (int i = 0; i < layer; i++) begin
            rows = rows_after(rows);
        end
        return rows;
    endfunction

endpackage

// File: rtl/wallace_csa_row.sv
// One 3:2 carry-save layer across a full row; the carry row is pre-shifted
// one column left and the carry out of the top column is discarded.
module wallace_csa_row #(
    parameter int W = 32
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic [W-1:0] z_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    logic [W-2:0] majority;

    assign sum_o    = x_i ^ y_i ^ z_i;
    assign majority = (x_i[W-2:0] & y_i[W-2:0]) |
                      (x_i[W-2:0] & z_i[W-2:0]) |
                      (y_i[W-2:0] & z_i[W-2:0]);
    assign carry_o  = {majority, 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined Wallace-tree multiplier (PP generation, 3:2 reduction,
// final add) with per-operation signed/unsigned mode and valid/ready flow control.
module wallace_mult_pipe
    import wallace_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int PROD_W = prod_w(WIDTH);
    localparam int N0     = WIDTH + 1;
    localparam int NL     = num_layers(N0);
    localparam logic [PROD_W-1:0] BW_CORR = PROD_W'(bw_correction(WIDTH));

    stage_ctrl_t         s1Ctrl_q;
    stage_ctrl_t         s1Ctrl_d;
    logic [PROD_W-1:0]   ppRows_d [WIDTH];
    logic [PROD_W-1:0]   ppRows_q [WIDTH];

    logic                s2Valid_q;
    logic [TAG_W-1:0]    s2Tag_q;
    logic [PROD_W-1:0]   sumRow_q;
    logic [PROD_W-1:0]   carryRow_q;

    logic                s3Valid_q;
    logic [TAG_W-1:0]    outTag_q;
    logic [PROD_W-1:0]   product_q;
    logic [PROD_W-1:0]   product_d;

    logic                load1;
    logic                load2;
    logic                load3;

    // A stage may load when it is empty or its content moves on this cycle.
    assign load3    = !s3Valid_q || out_ready;
    assign load2    = !s2Valid_q || load3;
    assign load1    = !s1Ctrl_q.valid || load2;
    assign in_ready = load1;

    always_comb begin
        s1Ctrl_d.valid       = in_valid;
        s1Ctrl_d.signed_mode = signed_mode;
        s1Ctrl_d.tag         = MAX_TAG_W'(in_tag);
    end

    // Cross terms involving exactly one operand MSB are inverted in signed mode.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            ppRows_d[i] = '0;
            for (int j = 0; j < WIDTH; j++) begin
                ppRows_d[i][i+j] = (a[j] & b[i]) ^
                                   (signed_mode && ((i == WIDTH-1) != (j == WIDTH-1)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Ctrl_q.valid <= 1'b0;
        end else if (load1) begin
            s1Ctrl_q.valid <= s1Ctrl_d.valid;
            if (in_valid) begin
                s1Ctrl_q.signed_mode <= s1Ctrl_d.signed_mode;
                s1Ctrl_q.tag         <= s1Ctrl_d.tag;
                ppRows_q             <= ppRows_d;
            end
        end
    end

    logic [PROD_W-1:0] tree [NL+1][N0];

    for (genvar k = 0; k < WIDTH; k++) begin : g_tree_in
        assign tree[0][k] = ppRows_q[k];
    end
    assign tree[0][WIDTH] = s1Ctrl_q.signed_mode ? BW_CORR : '0;

    // Each layer compresses rows in groups of three; leftovers pass straight down.
    for (genvar l = 0; l < NL; l++) begin : g_layer
        localparam int NIN  = rows_at_layer(N0, l);
        localparam int NG   = NIN / 3;
        localparam int NOUT = rows_after(NIN);

        for (genvar g = 0; g < NG; g++) begin : g_csa
            wallace_csa_row #(.W(PROD_W)) u_csa (
                .x_i     (tree[l][3*g]),
                .y_i     (tree[l][3*g+1]),
                .z_i     (tree[l][3*g+2]),
                .sum_o   (tree[l+1][2*g]),
                .carry_o (tree[l+1][2*g+1])
            );
        end

        for (genvar r = 0; r < NIN - 3*NG; r++) begin : g_pass
            assign tree[l+1][2*NG+r] = tree[l][3*NG+r];
        end

        for (genvar k = NOUT; k < N0; k++) begin : g_zero
            assign tree[l+1][k] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2Valid_q <= 1'b0;
        end else if (load2) begin
            s2Valid_q <= s1Ctrl_q.valid;
            if (s1Ctrl_q.valid) begin
                sumRow_q   <= tree[NL][0];
                carryRow_q <= tree[NL][1];
                s2Tag_q    <= s1Ctrl_q.tag[TAG_W-1:0];
            end
        end
    end

    assign product_d = sumRow_q + carryRow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s3Valid_q <= 1'b0;
            product_q <= '0;
            outTag_q  <= '0;
        end else if (load3) begin
            s3Valid_q <= s2Valid_q;
            if (s2Valid_q) begin
                product_q <= product_d;
                outTag_q  <= s2Tag_q;
            end
        end
    end

    assign out_valid = s3Valid_q;
    assign product   = product_q;
    assign out_tag   = outTag_q;

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Drives 8-, 16- and 32-bit multiplier instances in lockstep and checks them
// against an arithmetic reference model through an in-order scoreboard.
module tb_wallace_mult_pipe;
    import wallace_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        signed_mode;
    logic        out_ready;
    logic [3:0]  in_tag;
    logic [31:0] aSrc;
    logic [31:0] bSrc;

    logic        inReady8,  outValid8;
    logic        inReady16, outValid16;
    logic        inReady32, outValid32;
    logic [15:0] product8;
    logic [31:0] product16;
    logic [63:0] product32;
    logic [3:0]  outTag8, outTag16, outTag32;

    typedef struct {
        logic [15:0] p8;
        logic [31:0] p16;
        logic [63:0] p32;
        logic [3:0]  tag;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycle      = 0;
    bit   checkLat   = 1'b0;

    always #5 clk = ~clk;

    wallace_mult_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady8),
        .a(aSrc[7:0]), .b(bSrc[7:0]), .signed_mode(signed_mode), .in_tag(in_tag),
        .out_valid(outValid8), .out_ready(out_ready), .product(product8), .out_tag(outTag8)
    );

    wallace_mult_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady16),
        .a(aSrc[15:0]), .b(bSrc[15:0]), .signed_mode(signed_mode), .in_tag(in_tag),
        .out_valid(outValid16), .out_ready(out_ready), .product(product16), .out_tag(outTag16)
    );

    wallace_mult_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady32),
        .a(aSrc), .b(bSrc), .signed_mode(signed_mode), .in_tag(in_tag),
        .out_valid(outValid32), .out_ready(out_ready), .product(product32), .out_tag(outTag32)
    );

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] expd);
        compared++;
        if (got !== expd) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, expd);
        end
    endtask

    // Exact product from plain integer arithmetic on sign- or zero-extended operands.
    function automatic logic [63:0] refMult(input int w, input logic [31:0] av, input logic [31:0] bv, input bit s);
        logic [63:0] maskW;
        logic [63:0] ax;
        logic [63:0] bx;
        logic [63:0] maskP;
        maskW = (64'd1 << w) - 64'd1;
        ax    = {32'd0, av} & maskW;
        bx    = {32'd0, bv} & maskW;
        if (s) begin
            if (ax[w-1]) ax = ax | ~maskW;
            if (bx[w-1]) bx = bx | ~maskW;
        end
        maskP = (w >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*w)) - 64'd1);
        return (ax * bx) & maskP;
    endfunction

    task automatic observe();
        int   age;
        exp_t e;
        if (checkLat && sb.size() > 0) begin
            age = cycle - sb[0].acc;
            if (outValid16 || age >= NUM_STAGES)
                checkOutput("latency", 64'(age), 64'(NUM_STAGES));
        end
        if (outValid16 && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_out", 64'(outValid16), 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("prod16", 64'(product16), 64'(e.p16));
                checkOutput("tag16",  64'(outTag16),  64'(e.tag));
                checkOutput("valid8", 64'(outValid8), 64'd1);
                checkOutput("prod8",  64'(product8),  64'(e.p8));
                checkOutput("tag8",   64'(outTag8),   64'(e.tag));
                checkOutput("valid32", 64'(outValid32), 64'd1);
                checkOutput("prod32", product32,      e.p32);
                checkOutput("tag32",  64'(outTag32),  64'(e.tag));
            end
        end else if (outValid16 && sb.size() > 0) begin
            checkOutput("stall_prod", 64'(product16), 64'(sb[0].p16));
            checkOutput("stall_tag",  64'(outTag16),  64'(sb[0].tag));
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [31:0] av, input logic [31:0] bv,
                                 input bit m, input logic [3:0] t, input bit ordy,
                                 output bit accepted);
        exp_t e;
        @(negedge clk);
        in_valid    = v;
        aSrc        = av;
        bSrc        = bv;
        signed_mode = m;
        in_tag      = t;
        out_ready   = ordy;
        #1;
        observe();
        accepted = v && inReady16;
        if (accepted) begin
            e.p8  = 16'(refMult(8,  av, bv, m));
            e.p16 = 32'(refMult(16, av, bv, m));
            e.p32 = refMult(32, av, bv, m);
            e.tag = t;
            e.acc = cycle;
            sb.push_back(e);
        end
        @(posedge clk);
        cycle++;
    endtask

    task automatic sendOp(input logic [31:0] av, input logic [31:0] bv, input bit m, input logic [3:0] t);
        bit acc;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++)
            applyStimulus(1'b1, av, bv, m, t, 1'b1, acc);
        if (!acc) checkOutput("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1, acc);
    endtask

    task automatic drain();
        bit acc;
        for (int n = 0; n < 60 && sb.size() > 0; n++)
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1, acc);
        if (sb.size() != 0) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    logic [31:0] cornerA [8] = '{32'h0000_FFFF, 32'h0000_0000, 32'h0000_FFFF, 32'h0000_8000,
                                 32'h0000_8000, 32'h0000_7FFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] cornerB [8] = '{32'h0000_FFFF, 32'h0000_1234, 32'h0000_FFFF, 32'h0000_8000,
                                 32'h0000_0001, 32'h0000_8000, 32'hFFFF_FFFF, 32'h8000_0000};
    bit          cornerM [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          acc;
        int          accepts;
        logic [31:0] pa, pb;
        bit          pm;
        logic [3:0]  pt;

        rst = 1'b1; in_valid = 1'b0; aSrc = '0; bSrc = '0;
        signed_mode = 1'b0; in_tag = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_out_valid", 64'(outValid16), 64'd0);
        checkOutput("rst_product",   64'(product16),  64'd0);
        checkOutput("rst_out_tag",   64'(outTag16),   64'd0);
        checkOutput("rst_in_ready",  64'(inReady16),  64'd1);
        checkOutput("rst_valid8",    64'(outValid8),  64'd0);
        checkOutput("rst_prod32",    product32,       64'd0);
        @(posedge clk);

        $display("[TB] corner operands");
        checkLat = 1'b1;
        for (int i = 0; i < 8; i++)
            sendOp(cornerA[i], cornerB[i], cornerM[i], 4'(i));
        drain();

        $display("[TB] back-to-back mixed modes");
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, $urandom, $urandom, 1'(i % 2), 4'(i % 16), 1'b1, acc);
            checkOutput("accept_every_cycle", 64'(acc), 64'd1);
        end
        drain();

        $display("[TB] backpressure");
        checkLat = 1'b0;
        accepts  = 0;
        pa = $urandom; pb = $urandom; pm = 1'($urandom); pt = 4'd0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, pa, pb, pm, pt, 1'b0, acc);
            if (acc) begin
                accepts++;
                pa = $urandom; pb = $urandom; pm = 1'($urandom); pt = pt + 4'd1;
            end
        end
        checkOutput("stall_accepts", 64'(accepts), 64'd3);
        @(negedge clk);
        #1;
        checkOutput("stall_in_ready",  64'(inReady16),  64'd0);
        checkOutput("stall_out_valid", 64'(outValid16), 64'd1);
        @(posedge clk);
        cycle++;
        drain();
        idle(4);

        $display("[TB] reset mid-flight");
        checkLat = 1'b1;
        sendOp($urandom, $urandom, 1'b1, 4'd5);
        sendOp($urandom, $urandom, 1'b0, 4'd6);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        cycle++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 64'(outValid16), 64'd0);
        checkOutput("midrst_product",   64'(product16),  64'd0);
        checkOutput("midrst_in_ready",  64'(inReady16),  64'd1);
        checkOutput("midrst_valid32",   64'(outValid32), 64'd0);
        sb.delete();
        @(posedge clk);
        cycle++;
        idle(6);

        $display("[TB] recovery burst");
        for (int i = 0; i < 20; i++)
            sendOp($urandom, $urandom, 1'($urandom), 4'(i));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
